// File: rtl/multi_pulse_scheduler.sv
// N-channel programmable tick generator: per-channel period, pulse width and
// periodic/one-shot mode, with shadowed configuration applied at period wraps.
module multi_pulse_scheduler #(
    parameter int CLOCK_FREQ          = 50_000_000,
    parameter int DEFAULT_INTERVAL_MS = 60,
    parameter int DEFAULT_PERIOD      = (CLOCK_FREQ / 1000) * DEFAULT_INTERVAL_MS,
    parameter int NUM_CH              = 4,
    parameter int CNT_W               = 32,
    parameter int PW_W                = 8,
    localparam int CH_W               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [PW_W-1:0]   cfg_width,
    input  logic              cfg_mode,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] start,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DEF_P_RAW = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] DEF_P_EFF = CNT_W'((DEFAULT_PERIOD < 2) ? 2 : DEFAULT_PERIOD);

    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        return (p < CNT_W'(2)) ? CNT_W'(2) : p;
    endfunction

    // Width is limited to P-1 so every period has at least one low cycle.
    function automatic logic [PW_W-1:0] clamp_width(input logic [PW_W-1:0] w,
                                                    input logic [CNT_W-1:0] p);
        logic [CNT_W-1:0] lim;
        lim = p - CNT_W'(1);
        if (w == '0)
            return PW_W'(1);
        else if (CNT_W'(w) > lim)
            return PW_W'(lim);
        else
            return w;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
        logic [CNT_W-1:0] act_p_q, act_p_d, sh_p_q, sh_p_d, eff_p;
        logic [PW_W-1:0]  act_w_q, act_w_d, sh_w_q, sh_w_d, eff_w;
        logic [PW_W-1:0]  pw_q, pw_d;
        logic             act_m_q, act_m_d, sh_m_q, sh_m_d;
        logic             pulse_q, pulse_d;
        logic             en_prev_q, wr_hit, en_rise, cnt_wrap;

        assign wr_hit   = cfg_we && (cfg_ch == CH_W'(i));
        assign sh_p_d   = wr_hit ? cfg_period : sh_p_q;
        assign sh_w_d   = wr_hit ? cfg_width  : sh_w_q;
        assign sh_m_d   = wr_hit ? cfg_mode   : sh_m_q;
        assign eff_p    = clamp_period(sh_p_d);
        assign eff_w    = clamp_width(sh_w_d, eff_p);
        assign en_rise  = ch_en[i] && !en_prev_q;
        assign cnt_inc  = cnt_q + CNT_W'(1);
        assign cnt_wrap = (cnt_q == act_p_q - CNT_W'(1));

        always_comb begin
            // NOTE: every signal written here gets its default first, so no path infers a latch.
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = pulse_q;
            pw_d    = pw_q;
            act_p_d = act_p_q;
            act_w_d = act_w_q;
            act_m_d = act_m_q;
            case (state_q)
                IDLE: begin
                    // Idle channels track the shadow directly, including a same-cycle write.
                    act_p_d = eff_p;
                    act_w_d = eff_w;
                    act_m_d = sh_m_d;
                    cnt_d   = '0;
                    pulse_d = 1'b0;
                    if (ch_en[i] && (start[i] || (en_rise && !sh_m_d)))
                        state_d = RUN;
                end
                RUN: begin
                    if (!ch_en[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        pulse_d = 1'b0;
                    end else if (start[i]) begin
                        cnt_d   = '0;
                        pulse_d = 1'b0;
                    end else if (cnt_wrap) begin
                        // The pulse launched here keeps the width in force before the update.
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                        pw_d    = act_w_q;
                        act_p_d = eff_p;
                        act_w_d = eff_w;
                        act_m_d = sh_m_d;
                    end else begin
                        cnt_d = cnt_inc;
                        if (pulse_q && (cnt_inc >= CNT_W'(pw_q))) begin
                            pulse_d = 1'b0;
                            if (act_m_q) begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                pulse_q   <= 1'b0;
                pw_q      <= PW_W'(1);
                act_p_q   <= DEF_P_EFF;
                act_w_q   <= PW_W'(1);
                act_m_q   <= 1'b0;
                sh_p_q    <= DEF_P_RAW;
                sh_w_q    <= PW_W'(1);
                sh_m_q    <= 1'b0;
                en_prev_q <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments so every register samples pre-edge values.
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                pulse_q   <= pulse_d;
                pw_q      <= pw_d;
                act_p_q   <= act_p_d;
                act_w_q   <= act_w_d;
                act_m_q   <= act_m_d;
                sh_p_q    <= sh_p_d;
                sh_w_q    <= sh_w_d;
                sh_m_q    <= sh_m_d;
                en_prev_q <= ch_en[i];
            end
        end

        assign pulse_out[i] = pulse_q;
        assign busy[i]      = (state_q == RUN);
    end

endmodule

// File: tb/tb_multi_pulse_scheduler.sv
// Scoreboard bench for multi_pulse_scheduler: expected per-edge pulse/busy
// values are queued from the timing rules, then popped after each clock edge.
module tb_multi_pulse_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [31:0] cfg_period = '0;
    logic [7:0]  cfg_width = '0;
    logic        cfg_mode = 1'b0;
    logic [3:0]  ch_en = '0;
    logic [3:0]  start = '0;
    logic [3:0]  pulse_out;
    logic [3:0]  busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] pulse;
        logic [3:0] busy;
        int         edge_no;
    } exp_t;

    exp_t sb[$];

    multi_pulse_scheduler #(
        .CLOCK_FREQ(1000),
        .DEFAULT_INTERVAL_MS(5),
        .NUM_CH(4),
        .CNT_W(32),
        .PW_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_period(cfg_period),
        .cfg_width(cfg_width),
        .cfg_mode(cfg_mode),
        .ch_en(ch_en),
        .start(start),
        .pulse_out(pulse_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] m, input logic [3:0] p, input logic [3:0] b, input int k);
        exp_t e;
        e.mask    = m;
        e.pulse   = p & m;
        e.busy    = b & m;
        e.edge_no = k;
        sb.push_back(e);
    endtask

    task automatic set_cfg(input int ch, input int p, input int w, input logic m);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = 32'(p);
        cfg_width  = 8'(w);
        cfg_mode   = m;
    endtask

    task automatic write_cfg(input int ch, input int p, input int w, input logic m);
        set_cfg(ch, p, w, m);
        tick();
        cfg_we = 1'b0;
    endtask

    // Pulse level after edge k for a channel armed at edge 0 with period p, width w.
    function automatic logic per_hi(input int k, input int p, input int w);
        return (k >= p) && ((k % p) < w);
    endfunction

    task automatic test_reset();
        exp_t       e;
        logic [3:0] p;
        rst   = 1'b1;
        ch_en = 4'b0001;
        repeat (3) tick();
        total++;
        if (pulse_out !== 4'b0000) begin
            bad++;
            $display("FAIL reset pulse_out: got %b want 0000", pulse_out);
        end
        total++;
        if (busy !== 4'b0000) begin
            bad++;
            $display("FAIL reset busy: got %b want 0000", busy);
        end
        for (int k = 0; k <= 16; k++) begin
            p    = '0;
            p[0] = per_hi(k, 5, 1);
            push(4'b1111, p, 4'b0001, k);
        end
        rst = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            tick();
            e = sb.pop_front();
            total += 2;
            if ((pulse_out & e.mask) !== e.pulse) begin
                bad++;
                $display("FAIL default_period pulse edge %0d: got %b want %b", e.edge_no, pulse_out & e.mask, e.pulse);
            end
            if ((busy & e.mask) !== e.busy) begin
                bad++;
                $display("FAIL default_period busy edge %0d: got %b want %b", e.edge_no, busy & e.mask, e.busy);
            end
        end
        ch_en = 4'b0000;
        tick();
    endtask

    task automatic test_one_shot();
        exp_t       e;
        logic [3:0] p, b;
        write_cfg(1, 8, 3, 1'b1);
        for (int k = 0; k <= 19; k++) begin
            p    = '0;
            b    = '0;
            p[1] = (k >= 8) && (k <= 10);
            b[1] = (k <= 10);
            push(4'b0010, p, b, k);
        end
        for (int k = 0; k <= 19; k++) begin
            ch_en[1] = 1'b1;
            start[1] = (k == 0);
            tick();
            e = sb.pop_front();
            total += 2;
            if ((pulse_out & e.mask) !== e.pulse) begin
                bad++;
                $display("FAIL one_shot pulse edge %0d: got %b want %b", e.edge_no, pulse_out & e.mask, e.pulse);
            end
            if ((busy & e.mask) !== e.busy) begin
                bad++;
                $display("FAIL one_shot busy edge %0d: got %b want %b", e.edge_no, busy & e.mask, e.busy);
            end
        end
        ch_en[1] = 1'b0;
        tick();
        for (int k = 0; k <= 11; k++) push(4'b0010, 4'b0000, 4'b0000, k);
        for (int k = 0; k <= 11; k++) begin
            start[1] = (k == 0);
            tick();
            e = sb.pop_front();
            total += 2;
            if ((pulse_out & e.mask) !== e.pulse) begin
                bad++;
                $display("FAIL start_disabled pulse edge %0d: got %b want %b", e.edge_no, pulse_out & e.mask, e.pulse);
            end
            if ((busy & e.mask) !== e.busy) begin
                bad++;
                $display("FAIL start_disabled busy edge %0d: got %b want %b", e.edge_no, busy & e.mask, e.busy);
            end
        end
        start = '0;
    endtask

    task automatic test_reconfig();
        exp_t       e;
        logic [3:0] p, b;
        write_cfg(2, 10, 2, 1'b0);
        for (int k = 0; k <= 40; k++) begin
            p = '0;
            b = '0;
            if (k < 20)      p[2] = per_hi(k, 10, 2);
            else if (k < 24) p[2] = (k <= 21);
            else             p[2] = (((k - 24) % 4) == 0) && (k <= 32);
            b[2] = (k <= 32);
            push(4'b0100, p, b, k);
        end
        for (int k = 0; k <= 40; k++) begin
            ch_en[2] = 1'b1;
            if (k == 13)      set_cfg(2, 4, 1, 1'b0);
            else if (k == 30) set_cfg(2, 4, 1, 1'b1);
            else              cfg_we = 1'b0;
            tick();
            e = sb.pop_front();
            total += 2;
            if ((pulse_out & e.mask) !== e.pulse) begin
                bad++;
                $display("FAIL reconfig pulse edge %0d: got %b want %b", e.edge_no, pulse_out & e.mask, e.pulse);
            end
            if ((busy & e.mask) !== e.busy) begin
                bad++;
                $display("FAIL reconfig busy edge %0d: got %b want %b", e.edge_no, busy & e.mask, e.busy);
            end
        end
        cfg_we   = 1'b0;
        ch_en[2] = 1'b0;
        tick();
    endtask

    task automatic test_clamp();
        exp_t       e;
        logic [3:0] p;
        write_cfg(3, 0, 0, 1'b0);
        for (int k = 0; k <= 11; k++) begin
            p    = '0;
            p[3] = per_hi(k, 2, 1);
            push(4'b1000, p, 4'b1000, k);
        end
        for (int k = 0; k <= 11; k++) begin
            ch_en[3] = 1'b1;
            tick();
            e = sb.pop_front();
            total += 2;
            if ((pulse_out & e.mask) !== e.pulse) begin
                bad++;
                $display("FAIL clamp_zero pulse edge %0d: got %b want %b", e.edge_no, pulse_out & e.mask, e.pulse);
            end
            if ((busy & e.mask) !== e.busy) begin
                bad++;
                $display("FAIL clamp_zero busy edge %0d: got %b want %b", e.edge_no, busy & e.mask, e.busy);
            end
        end
        ch_en[3] = 1'b0;
        tick();
        write_cfg(3, 3, 200, 1'b0);
        for (int k = 0; k <= 14; k++) begin
            p    = '0;
            p[3] = per_hi(k, 3, 2);
            push(4'b1000, p, 4'b1000, k);
        end
        for (int k = 0; k <= 14; k++) begin
            ch_en[3] = 1'b1;
            tick();
            e = sb.pop_front();
            total += 2;
            if ((pulse_out & e.mask) !== e.pulse) begin
                bad++;
                $display("FAIL clamp_wide pulse edge %0d: got %b want %b", e.edge_no, pulse_out & e.mask, e.pulse);
            end
            if ((busy & e.mask) !== e.busy) begin
                bad++;
                $display("FAIL clamp_wide busy edge %0d: got %b want %b", e.edge_no, busy & e.mask, e.busy);
            end
        end
        ch_en[3] = 1'b0;
        tick();
    endtask

    task automatic test_abort_restart();
        exp_t       e;
        logic [3:0] p, b;
        write_cfg(0, 6, 3, 1'b0);
        for (int k = 0; k <= 12; k++) begin
            p    = '0;
            b    = '0;
            p[0] = (k == 6);
            b[0] = (k <= 6);
            push(4'b0001, p, b, k);
        end
        for (int k = 0; k <= 12; k++) begin
            ch_en[0] = (k < 7);
            tick();
            e = sb.pop_front();
            total += 2;
            if ((pulse_out & e.mask) !== e.pulse) begin
                bad++;
                $display("FAIL abort pulse edge %0d: got %b want %b", e.edge_no, pulse_out & e.mask, e.pulse);
            end
            if ((busy & e.mask) !== e.busy) begin
                bad++;
                $display("FAIL abort busy edge %0d: got %b want %b", e.edge_no, busy & e.mask, e.busy);
            end
        end
        for (int k = 0; k <= 24; k++) begin
            p    = '0;
            p[0] = ((k >= 6) && (k <= 8)) || ((k >= 16) && (((k - 16) % 6) < 3));
            push(4'b0001, p, 4'b0001, k);
        end
        for (int k = 0; k <= 24; k++) begin
            ch_en[0] = 1'b1;
            start[0] = (k == 10);
            tick();
            e = sb.pop_front();
            total += 2;
            if ((pulse_out & e.mask) !== e.pulse) begin
                bad++;
                $display("FAIL restart pulse edge %0d: got %b want %b", e.edge_no, pulse_out & e.mask, e.pulse);
            end
            if ((busy & e.mask) !== e.busy) begin
                bad++;
                $display("FAIL restart busy edge %0d: got %b want %b", e.edge_no, busy & e.mask, e.busy);
            end
        end
        start    = '0;
        ch_en[0] = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [3:0] p, b;
        write_cfg(0, 3, 1, 1'b0);
        write_cfg(2, 5, 2, 1'b0);
        write_cfg(3, 7, 1, 1'b1);
        for (int k = 0; k <= 16; k++) begin
            p    = '0;
            p[0] = per_hi(k, 3, 1);
            p[1] = per_hi(k, 4, 1);
            p[2] = per_hi(k, 5, 2);
            p[3] = (k == 7);
            b    = 4'b0111;
            b[3] = (k <= 7);
            push(4'b1111, p, b, k);
        end
        for (int k = 0; k <= 16; k++) begin
            ch_en = 4'b1111;
            if (k == 0) begin
                start = 4'b1111;
                set_cfg(1, 4, 1, 1'b0);
            end else begin
                start  = '0;
                cfg_we = 1'b0;
            end
            tick();
            e = sb.pop_front();
            total += 2;
            if ((pulse_out & e.mask) !== e.pulse) begin
                bad++;
                $display("FAIL parallel pulse edge %0d: got %b want %b", e.edge_no, pulse_out & e.mask, e.pulse);
            end
            if ((busy & e.mask) !== e.busy) begin
                bad++;
                $display("FAIL parallel busy edge %0d: got %b want %b", e.edge_no, busy & e.mask, e.busy);
            end
        end
        rst = 1'b1;
        tick();
        total++;
        if (pulse_out !== 4'b0000) begin
            bad++;
            $display("FAIL midpulse_reset pulse_out: got %b want 0000", pulse_out);
        end
        total++;
        if (busy !== 4'b0000) begin
            bad++;
            $display("FAIL midpulse_reset busy: got %b want 0000", busy);
        end
        for (int k = 0; k <= 11; k++) begin
            p = per_hi(k, 5, 1) ? 4'b1111 : 4'b0000;
            push(4'b1111, p, 4'b1111, k);
        end
        rst = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            tick();
            e = sb.pop_front();
            total += 2;
            if ((pulse_out & e.mask) !== e.pulse) begin
                bad++;
                $display("FAIL post_reset_default pulse edge %0d: got %b want %b", e.edge_no, pulse_out & e.mask, e.pulse);
            end
            if ((busy & e.mask) !== e.busy) begin
                bad++;
                $display("FAIL post_reset_default busy edge %0d: got %b want %b", e.edge_no, busy & e.mask, e.busy);
            end
        end
        ch_en = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_reconfig();
        test_clamp();
        test_abort_restart();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_pulse_scheduler.md
Name: multi_pulse_scheduler

Overview:
- N-channel programmable tick generator; successor to the single fixed-interval pulse generator.
- Each channel has its own runtime period, pulse width and mode: periodic or one-shot.
- Provides sample/refresh strobes to the sensor-sampling, debounce and display-refresh logic of the counter system from one shared block.
- Configured through a simple write port; configuration changes apply glitch-free at period boundaries.

Parameters:
- CLOCK_FREQ, 50_000_000: clk frequency in Hz; used only to derive DEFAULT_PERIOD.
- DEFAULT_INTERVAL_MS, 60: reset interval for every channel.
- DEFAULT_PERIOD, (CLOCK_FREQ/1000)*DEFAULT_INTERVAL_MS: reset period in cycles.
- NUM_CH, 4: number of channels (1..16).
- CNT_W, 32: period counter width.
- PW_W, 8: pulse-width field width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_period  in  CNT_W  period in clk cycles
- cfg_width  in  PW_W  high time in clk cycles
- cfg_mode  in  1  0 = periodic, 1 = one-shot
- ch_en  in  NUM_CH  per-channel enable (level)
- start  in  NUM_CH  per-channel arm/restart strobe
- pulse_out  out  NUM_CH  registered pulse outputs
- busy  out  NUM_CH  channel armed or counting

Behaviour:
- Reset: active and shadow config = {DEFAULT_PERIOD, width 1, periodic}; counters 0; pulse_out = 0, busy = 0; all channels IDLE; enable-edge history = 0.
- Consequence: a channel with ch_en held at 1 through reset arms on the first cycle after rst falls.
- Effective values:
  - P = max(period, 2).
  - W = width clamped to 1..P-1.
  - Clamping is applied when config becomes active.
- States per channel: IDLE, RUN.
- IDLE -> RUN (arm): counter <= 0, busy <= 1. Arm occurs on:
  - the ch_en rising edge in periodic mode, or
  - start while ch_en = 1 in either mode.
- start while ch_en = 0: ignored.
- Timing (arm sampled at edge 0):
  - pulse_out high during cycles following edges P .. P+W-1;
  - low from edge P+W.
- Periodic: rises repeat every P cycles (edges P, 2P, 3P, ...) while ch_en = 1.
- One-shot: exactly one pulse. Channel returns to IDLE and busy <= 0 at the same edge pulse_out falls (edge P+W).
- start while RUN: restart. Counter <= 0, pulse_out <= 0 at that edge; next rise P cycles later.
- ch_en falling (any state): at next edge, pulse_out <= 0, busy <= 0, IDLE, counter <= 0. Any pending one-shot is cancelled.
- Config write (cfg_we = 1) goes to the shadow registers of cfg_ch. Shadow is copied to active:
  - immediately if the channel is IDLE;
  - at the next period wrap (edge where a new pulse rises) if RUN;
  - never mid-pulse, so a width change never truncates or extends the current pulse.
- cfg_we and arm for the same channel in the same cycle: new config is used for that arm.
- cfg_ch >= NUM_CH: write ignored.
- Mode change to one-shot while running periodic: takes effect at next wrap; that pulse is the final one.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Counter compare uses CNT_W-bit unsigned arithmetic; no overflow possible since counter < P.
- rst asserted mid-pulse: pulse_out low at the next edge; all config returns to default.

Test Plan:
- Reset with ch_en = 4'b0001, default params (CLOCK_FREQ = 1000, DEFAULT_INTERVAL_MS = 5 gives P = 5) -> ch0 pulse_out high 1 cycle at edges 5, 10, 15 after rst release; other channels stay low, busy = 4'b0001.
- Write ch1 {P=8, W=3, one-shot}, ch_en[1] = 1, start[1] at edge 0 -> pulse_out[1] high for edges 8..10; busy[1] falls at edge 11; no further pulses. Repeat with start[1] = 1 and ch_en[1] = 0 -> no response.
- Periodic ch2 P = 10, W = 2; write {P=4, W=1} at edge 13 -> pulse at 20 still W = 2; new config active from edge 20 wrap, so next rises at 24, 28 with W = 1.
- Clamping: write P = 0, W = 0 -> behaves as P = 2, W = 1 (toggles each cycle). Write P = 3, W = 200 -> W = 2; pattern high, high, low repeating.
- Abort/restart: deassert ch_en[0] during its pulse -> pulse_out[0] = 0 next edge, busy = 0. start on a running periodic channel 2 cycles before a rise -> no rise there; next rise P cycles after start.
- rst pulsed mid-pulse on all channels after custom config -> all outputs 0 next edge; channels resume with DEFAULT_PERIOD, width 1.
